// File: rtl/bop_resolver.sv
// Purpose: consumer end of the buffer-of-predictions; checks each MA-stage
//          prediction against its resolved outcome and repairs mispredicts.
// Latency: pop/stall are combinational; redirect/flush/update follow one cycle later.
// Backpressure: stalls MA while a predicted instruction's BOP entry is not at the
//          head; gives up after WAIT_MAX waiting cycles and repairs as a mispredict.
//
// Ports:
//   s_clk_i, s_reset_i (sync, active-high), s_flush_i (external flush)
//   s_ma_*            : instruction in MA (valid/pred/toc/rvc/pc/resolved target)
//   s_bop_data_i/ready: BOP head entry; s_bop_pop_o pops it, s_bop_flush_o empties it
//   s_stall_o         : hold MA
//   s_redirect_o/addr : fetch redirect
//   s_upd_*           : predictor update (clear=1 invalidates, 0 writes target)
//   s_mispred_cnt_o   : saturating mispredict count; s_fault_o: sticky timeout flag
module bop_resolver #(
  parameter int unsigned PW       = 31,
  parameter int unsigned WAIT_MAX = 7,
  parameter int unsigned CW       = 16
) (
  input  logic          s_clk_i,
  input  logic          s_reset_i,
  input  logic          s_flush_i,
  input  logic          s_ma_valid_i,
  input  logic          s_ma_pred_i,
  input  logic          s_ma_toc_i,
  input  logic          s_ma_rvc_i,
  input  logic [31:0]   s_ma_pc_i,
  input  logic [31:0]   s_ma_target_i,
  input  logic [PW-1:0] s_bop_data_i,
  input  logic          s_bop_ready_i,
  output logic          s_bop_pop_o,
  output logic          s_bop_flush_o,
  output logic          s_stall_o,
  output logic          s_redirect_o,
  output logic [31:0]   s_redirect_addr_o,
  output logic          s_upd_valid_o,
  output logic          s_upd_clear_o,
  output logic [31:0]   s_upd_pc_o,
  output logic [31:0]   s_upd_target_o,
  output logic [CW-1:0] s_mispred_cnt_o,
  output logic          s_fault_o
);

  typedef enum logic [0:0] {ST_RUN, ST_WAIT} state_t;

  localparam logic [7:0] WAIT_MAX_C = 8'(WAIT_MAX);

  state_t        state_q, state_d;
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic          resp_q, resp_d;          // one-cycle mispredict response pulse
  logic [31:0]   addr_q, addr_d;          // redirect address, also the update target
  logic          upd_clear_q, upd_clear_d;
  logic [31:0]   upd_pc_q, upd_pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fault_q, fault_d;

  logic        timeout;
  logic        resolve;
  logic        tgt_hit;
  logic        mispred;
  logic [31:0] seq_addr;
  logic [31:0] next_addr;

  // An external flush squashes the redirect/update but still empties the BOP.
  assign s_redirect_o  = resp_q & ~s_flush_i;
  assign s_upd_valid_o = resp_q & ~s_flush_i;
  assign s_bop_flush_o = resp_q | s_flush_i;

  assign timeout = (state_q == ST_WAIT) && (wait_cnt_q == WAIT_MAX_C) && !s_bop_ready_i;

  // While a redirect is on the way out, the instruction in MA is younger
  // than the mispredict and is about to be squashed, so it is ignored.
  assign s_stall_o = s_ma_valid_i & s_ma_pred_i & ~s_bop_ready_i & ~s_flush_i
                   & ~s_redirect_o & ~timeout;
  assign resolve   = s_ma_valid_i & ~s_stall_o & ~s_flush_i & ~s_redirect_o;
  assign s_bop_pop_o = resolve & s_ma_pred_i & s_bop_ready_i;

  assign tgt_hit   = (s_bop_data_i == s_ma_target_i[PW:1]);
  assign seq_addr  = s_ma_pc_i + (s_ma_rvc_i ? 32'd2 : 32'd4);
  assign next_addr = s_ma_toc_i ? s_ma_target_i : seq_addr;

  // A resolve with pred set and no ready entry can only be the timeout case,
  // so the target comparison is only meaningful when timeout is low.
  assign mispred = resolve & (timeout
                            | (s_ma_pred_i & s_ma_toc_i & ~tgt_hit)
                            | (s_ma_pred_i ^ s_ma_toc_i));

  always_comb begin
    state_d     = s_stall_o ? ST_WAIT : ST_RUN;
    wait_cnt_d  = 8'd0;
    resp_d      = mispred;
    addr_d      = addr_q;
    upd_clear_d = upd_clear_q;
    upd_pc_d    = upd_pc_q;
    cnt_d       = cnt_q;
    fault_d     = fault_q | (resolve & timeout);

    // Counter only advances for stalled cycles spent in WAIT; the cycle that
    // enters WAIT leaves it at zero.
    if (s_stall_o && state_q == ST_WAIT) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end

    if (mispred) begin
      addr_d      = next_addr;
      upd_clear_d = timeout | ~s_ma_toc_i;
      upd_pc_d    = s_ma_pc_i;
      if (cnt_q != {CW{1'b1}}) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= 8'd0;
      resp_q      <= 1'b0;
      addr_q      <= 32'd0;
      upd_clear_q <= 1'b0;
      upd_pc_q    <= 32'd0;
      cnt_q       <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      resp_q      <= resp_d;
      addr_q      <= addr_d;
      upd_clear_q <= upd_clear_d;
      upd_pc_q    <= upd_pc_d;
      cnt_q       <= cnt_d;
      fault_q     <= fault_d;
    end
  end

  assign s_redirect_addr_o = addr_q;
  assign s_upd_target_o    = addr_q;
  assign s_upd_clear_o     = upd_clear_q;
  assign s_upd_pc_o        = upd_pc_q;
  assign s_mispred_cnt_o   = cnt_q;
  assign s_fault_o         = fault_q;

endmodule

// File: tb/tb_bop_resolver.sv
// Purpose: directed bench for bop_resolver with a response scoreboard.
// Latency: inputs driven on the falling edge, outputs sampled 1ns later.
// Backpressure: timeout waits are bounded by a fixed cycle budget.
module tb_bop_resolver;

  logic        s_clk_i = 1'b0;
  logic        s_reset_i;
  logic        s_flush_i;
  logic        s_ma_valid_i;
  logic        s_ma_pred_i;
  logic        s_ma_toc_i;
  logic        s_ma_rvc_i;
  logic [31:0] s_ma_pc_i;
  logic [31:0] s_ma_target_i;
  logic [30:0] s_bop_data_i;
  logic        s_bop_ready_i;
  logic        s_bop_pop_o;
  logic        s_bop_flush_o;
  logic        s_stall_o;
  logic        s_redirect_o;
  logic [31:0] s_redirect_addr_o;
  logic        s_upd_valid_o;
  logic        s_upd_clear_o;
  logic [31:0] s_upd_pc_o;
  logic [31:0] s_upd_target_o;
  logic [15:0] s_mispred_cnt_o;
  logic        s_fault_o;

  // Narrow-counter instance sharing the same stimulus, to reach saturation quickly.
  logic        unused_sat_pop, unused_sat_flush, unused_sat_stall, unused_sat_redir;
  logic        unused_sat_uvld, unused_sat_uclr, unused_sat_fault;
  logic [31:0] unused_sat_addr, unused_sat_upc, unused_sat_utgt;
  logic [2:0]  sat_cnt;

  always #5 s_clk_i = ~s_clk_i;

  bop_resolver #(.PW(31), .WAIT_MAX(7), .CW(16)) dut (
    .s_clk_i(s_clk_i), .s_reset_i(s_reset_i), .s_flush_i(s_flush_i),
    .s_ma_valid_i(s_ma_valid_i), .s_ma_pred_i(s_ma_pred_i), .s_ma_toc_i(s_ma_toc_i),
    .s_ma_rvc_i(s_ma_rvc_i), .s_ma_pc_i(s_ma_pc_i), .s_ma_target_i(s_ma_target_i),
    .s_bop_data_i(s_bop_data_i), .s_bop_ready_i(s_bop_ready_i),
    .s_bop_pop_o(s_bop_pop_o), .s_bop_flush_o(s_bop_flush_o), .s_stall_o(s_stall_o),
    .s_redirect_o(s_redirect_o), .s_redirect_addr_o(s_redirect_addr_o),
    .s_upd_valid_o(s_upd_valid_o), .s_upd_clear_o(s_upd_clear_o),
    .s_upd_pc_o(s_upd_pc_o), .s_upd_target_o(s_upd_target_o),
    .s_mispred_cnt_o(s_mispred_cnt_o), .s_fault_o(s_fault_o)
  );

  bop_resolver #(.PW(31), .WAIT_MAX(7), .CW(3)) u_sat (
    .s_clk_i(s_clk_i), .s_reset_i(s_reset_i), .s_flush_i(s_flush_i),
    .s_ma_valid_i(s_ma_valid_i), .s_ma_pred_i(s_ma_pred_i), .s_ma_toc_i(s_ma_toc_i),
    .s_ma_rvc_i(s_ma_rvc_i), .s_ma_pc_i(s_ma_pc_i), .s_ma_target_i(s_ma_target_i),
    .s_bop_data_i(s_bop_data_i), .s_bop_ready_i(s_bop_ready_i),
    .s_bop_pop_o(unused_sat_pop), .s_bop_flush_o(unused_sat_flush),
    .s_stall_o(unused_sat_stall), .s_redirect_o(unused_sat_redir),
    .s_redirect_addr_o(unused_sat_addr), .s_upd_valid_o(unused_sat_uvld),
    .s_upd_clear_o(unused_sat_uclr), .s_upd_pc_o(unused_sat_upc),
    .s_upd_target_o(unused_sat_utgt), .s_mispred_cnt_o(sat_cnt),
    .s_fault_o(unused_sat_fault)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        clr;
    logic [31:0] pc;
  } resp_t;

  resp_t       sb_q[$];
  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;
  int unsigned n_total = 0;
  int unsigned exp_cnt = 0;
  int unsigned stalled;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of MA/BOP inputs on the falling edge and settle.
  task automatic step(input logic v, input logic p, input logic t, input logic r,
                      input logic [31:0] pc, input logic [31:0] tgt,
                      input logic rdy, input logic [30:0] dat, input logic fl);
    @(negedge s_clk_i);
    s_ma_valid_i  = v;
    s_ma_pred_i   = p;
    s_ma_toc_i    = t;
    s_ma_rvc_i    = r;
    s_ma_pc_i     = pc;
    s_ma_target_i = tgt;
    s_bop_ready_i = rdy;
    s_bop_data_i  = dat;
    s_flush_i     = fl;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 31'h0, 1'b0);
  endtask

  task automatic push(input logic [31:0] addr, input logic clr, input logic [31:0] pc);
    resp_t e;
    e.addr = addr;
    e.clr  = clr;
    e.pc   = pc;
    sb_q.push_back(e);
    exp_cnt++;
  endtask

  // Called in the cycle after a mispredict: the response pulse must match the
  // oldest scoreboard entry.
  task automatic expect_resp(input string tag);
    resp_t e;
    chk({tag, "_redirect"}, 32'(s_redirect_o), 32'd1);
    chk({tag, "_bop_flush"}, 32'(s_bop_flush_o), 32'd1);
    chk({tag, "_upd_valid"}, 32'(s_upd_valid_o), 32'd1);
    chk({tag, "_sb_depth"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_redirect_addr"}, s_redirect_addr_o, e.addr);
      chk({tag, "_upd_clear"}, 32'(s_upd_clear_o), 32'(e.clr));
      chk({tag, "_upd_pc"}, s_upd_pc_o, e.pc);
      if (!e.clr) chk({tag, "_upd_target"}, s_upd_target_o, e.addr);
    end
    chk({tag, "_cnt"}, 32'(s_mispred_cnt_o), exp_cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d checks done", n_total);
    $fatal(1);
  end

  initial begin
    s_reset_i = 1'b1;
    idle();
    idle();
    // Reset state
    chk("rst_redirect", 32'(s_redirect_o), 32'd0);
    chk("rst_bop_flush", 32'(s_bop_flush_o), 32'd0);
    chk("rst_upd_valid", 32'(s_upd_valid_o), 32'd0);
    chk("rst_addr", s_redirect_addr_o, 32'd0);
    chk("rst_upd_pc", s_upd_pc_o, 32'd0);
    chk("rst_cnt", 32'(s_mispred_cnt_o), 32'd0);
    chk("rst_fault", 32'(s_fault_o), 32'd0);
    chk("rst_stall", 32'(s_stall_o), 32'd0);
    chk("rst_pop", 32'(s_bop_pop_o), 32'd0);
    s_reset_i = 1'b0;
    idle();

    // Correct prediction
    step(1, 1, 1, 0, 32'h100, 32'h0000_1000, 1, 31'h800, 0);
    chk("ok_pop", 32'(s_bop_pop_o), 32'd1);
    chk("ok_stall", 32'(s_stall_o), 32'd0);
    idle();
    chk("ok_redirect", 32'(s_redirect_o), 32'd0);
    chk("ok_bop_flush", 32'(s_bop_flush_o), 32'd0);
    chk("ok_cnt", 32'(s_mispred_cnt_o), 32'd0);

    // Wrong target
    step(1, 1, 1, 0, 32'h100, 32'h0000_2000, 1, 31'h800, 0);
    chk("wt_pop", 32'(s_bop_pop_o), 32'd1);
    push(32'h0000_2000, 1'b0, 32'h100);
    idle();
    expect_resp("wt");
    idle();
    chk("wt_pulse_end", 32'(s_redirect_o), 32'd0);
    chk("wt_addr_hold", s_redirect_addr_o, 32'h0000_2000);

    // Predicted taken, actually not taken, compressed
    step(1, 1, 0, 1, 32'h0000_0FFE, 32'h0000_5000, 1, 31'h900, 0);
    chk("nt_pop", 32'(s_bop_pop_o), 32'd1);
    push(32'h0000_1000, 1'b1, 32'h0000_0FFE);
    idle();
    expect_resp("nt");

    // Not predicted, actually taken: learn, no pop
    step(1, 0, 1, 0, 32'h200, 32'h0000_3000, 1, 31'h0, 0);
    chk("learn_pop", 32'(s_bop_pop_o), 32'd0);
    push(32'h0000_3000, 1'b0, 32'h200);
    idle();
    expect_resp("learn");

    // Neither predicted nor taken: nothing happens
    step(1, 0, 0, 0, 32'h300, 32'h0, 1, 31'h0, 0);
    chk("nop_pop", 32'(s_bop_pop_o), 32'd0);
    idle();
    chk("nop_redirect", 32'(s_redirect_o), 32'd0);
    chk("nop_cnt", 32'(s_mispred_cnt_o), exp_cnt);

    // Fall-through address wraps at the top of the address space
    step(1, 1, 0, 0, 32'hFFFF_FFFE, 32'h0, 1, 31'h1, 0);
    push(32'h0000_0002, 1'b1, 32'hFFFF_FFFE);
    idle();
    expect_resp("wrap");

    // Late BOP entry: three stalled cycles, then pop
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 0, 32'h100, 32'h0000_1000, 0, 31'h0, 0);
      chk("late_stall", 32'(s_stall_o), 32'd1);
      chk("late_no_pop", 32'(s_bop_pop_o), 32'd0);
    end
    step(1, 1, 1, 0, 32'h100, 32'h0000_1000, 1, 31'h800, 0);
    chk("late_stall_drop", 32'(s_stall_o), 32'd0);
    chk("late_pop", 32'(s_bop_pop_o), 32'd1);
    idle();
    chk("late_redirect", 32'(s_redirect_o), 32'd0);
    chk("late_cnt", 32'(s_mispred_cnt_o), exp_cnt);

    // Timeout: entry never arrives (fresh wait count proves the FSM returned to RUN)
    step(1, 1, 0, 0, 32'h400, 32'h0, 0, 31'h0, 0);
    stalled = 0;
    for (int i = 0; i < 20 && s_stall_o; i++) begin
      stalled++;
      step(1, 1, 0, 0, 32'h400, 32'h0, 0, 31'h0, 0);
    end
    chk("to_stalled_cycles", stalled, 32'd8);
    chk("to_stall_low", 32'(s_stall_o), 32'd0);
    chk("to_no_pop", 32'(s_bop_pop_o), 32'd0);
    push(32'h0000_0404, 1'b1, 32'h400);
    idle();
    expect_resp("to");
    chk("to_fault", 32'(s_fault_o), 32'd1);
    idle();
    idle();
    chk("to_fault_sticky", 32'(s_fault_o), 32'd1);

    // Flush beats a pending redirect
    step(1, 0, 1, 0, 32'h500, 32'h0000_6000, 1, 31'h0, 0);
    exp_cnt++;
    step(0, 0, 0, 0, 32'h0, 32'h0, 0, 31'h0, 1);
    chk("fl_redirect", 32'(s_redirect_o), 32'd0);
    chk("fl_bop_flush", 32'(s_bop_flush_o), 32'd1);
    chk("fl_upd_valid", 32'(s_upd_valid_o), 32'd0);
    chk("fl_addr", s_redirect_addr_o, 32'h0000_6000);
    chk("fl_cnt", 32'(s_mispred_cnt_o), exp_cnt);

    // Flush together with a would-be mispredict: no resolve, no pop
    step(1, 1, 1, 0, 32'h100, 32'h0000_2000, 1, 31'h800, 1);
    chk("flr_pop", 32'(s_bop_pop_o), 32'd0);
    chk("flr_stall", 32'(s_stall_o), 32'd0);
    idle();
    chk("flr_redirect", 32'(s_redirect_o), 32'd0);
    chk("flr_bop_flush", 32'(s_bop_flush_o), 32'd0);
    chk("flr_cnt", 32'(s_mispred_cnt_o), exp_cnt);

    // Flush during WAIT releases the stall without popping
    step(1, 1, 1, 0, 32'h100, 32'h0000_1000, 0, 31'h0, 0);
    step(1, 1, 1, 0, 32'h100, 32'h0000_1000, 0, 31'h0, 0);
    chk("flw_stall", 32'(s_stall_o), 32'd1);
    step(1, 1, 1, 0, 32'h100, 32'h0000_1000, 0, 31'h0, 1);
    chk("flw_stall_drop", 32'(s_stall_o), 32'd0);
    chk("flw_no_pop", 32'(s_bop_pop_o), 32'd0);
    step(1, 1, 1, 0, 32'h100, 32'h0000_1000, 1, 31'h800, 0);
    chk("flw_pop", 32'(s_bop_pop_o), 32'd1);
    idle();
    chk("flw_redirect", 32'(s_redirect_o), 32'd0);
    chk("flw_fault", 32'(s_fault_o), 32'd1);

    // More mispredicts to push the narrow counter into saturation
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 0, 32'h700 + 32'(i * 4), 32'h0000_8000 + 32'(i * 16), 1, 31'h0, 0);
      push(32'h0000_8000 + 32'(i * 16), 1'b0, 32'h700 + 32'(i * 4));
      idle();
      expect_resp("more");
    end
    chk("sat_cnt", 32'(sat_cnt), (exp_cnt > 32'd7) ? 32'd7 : exp_cnt);
    chk("wide_cnt", 32'(s_mispred_cnt_o), exp_cnt);
    step(1, 1, 0, 0, 32'h900, 32'h0, 1, 31'h0, 0);
    push(32'h0000_0904, 1'b1, 32'h900);
    idle();
    expect_resp("sat_more");
    chk("sat_hold", 32'(sat_cnt), 32'd7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
